// File: rtl/spike_packet_queue.sv
`default_nettype none
// ============================================================================
// Module      : spike_packet_queue
// Description : Captures per-slot spike events from the network interface
//               stage, serialises them through a round-robin arbiter into a
//               {destination, source} packet FIFO, and presents the packets
//               to the NoC router injection port over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_packet_queue #(
    parameter int NUM_SLOTS  = 10,
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic                          clear,
    input  logic [NUM_SLOTS-1:0]          in_valid,
    input  logic [NUM_SLOTS*ADDR_W-1:0]   in_source,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ADDR_W-1:0]             out_dest,
    output logic [ADDR_W-1:0]             out_source,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]              drop_count
);

    localparam int c_SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int c_AW     = $clog2(FIFO_DEPTH);
    localparam int c_CW     = c_AW + 1;
    // Wide enough to hold the counter plus every slot dropping in one cycle.
    localparam int c_DW     = CNT_W + c_SLOT_W + 1;

    // (base + k) mod NUM_SLOTS, with base < NUM_SLOTS and k <= NUM_SLOTS.
    function automatic logic [c_SLOT_W-1:0] wrap_add(input logic [c_SLOT_W-1:0] base,
                                                     input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_SLOTS) s = s - NUM_SLOTS;
        return c_SLOT_W'(s);
    endfunction

    // Slot capture state
    logic [NUM_SLOTS-1:0]  r_pending;
    logic [ADDR_W-1:0]     r_src [NUM_SLOTS];
    logic [c_SLOT_W-1:0]   r_ptr;
    logic [CNT_W-1:0]      r_drop;

    // Packet FIFO state
    logic [ADDR_W-1:0]     r_mem_dest [FIFO_DEPTH];
    logic [ADDR_W-1:0]     r_mem_src  [FIFO_DEPTH];
    logic [c_AW-1:0]       r_wr;
    logic [c_AW-1:0]       r_rd;
    logic [c_CW-1:0]       r_count;

    // Arbitration and bookkeeping
    logic [c_SLOT_W-1:0]   w_scan [NUM_SLOTS];
    logic                  w_found;
    logic [c_SLOT_W-1:0]   w_gnt_idx;
    logic                  w_full;
    logic                  w_grant_en;
    logic [NUM_SLOTS-1:0]  w_gnt_vec;
    logic [NUM_SLOTS-1:0]  w_drop_vec;
    logic [c_SLOT_W:0]     w_drop_n;
    logic [c_DW-1:0]       w_drop_sum;
    logic [CNT_W-1:0]      w_drop_next;
    logic                  w_push;
    logic                  w_pop;

    // Scan order starts at the round-robin pointer and wraps.
    generate
        for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_scan
            assign w_scan[k] = wrap_add(r_ptr, k);
        end
    endgenerate

    // Fullness is judged on the occupancy at the start of the cycle, so a
    // same-cycle pop never makes room for a push.
    assign w_full     = (r_count == c_CW'(FIFO_DEPTH));
    assign w_grant_en = w_found && !w_full && !clear;
    assign w_push     = w_grant_en;
    assign w_pop      = out_valid && out_ready;

    // Pick the first pending slot in scan order.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (!w_found && r_pending[w_scan[k]]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_scan[k];
            end
        end
    end

    // Per-slot grant and collision flags, and saturating drop accumulation.
    always_comb begin
        w_gnt_vec  = '0;
        w_drop_vec = '0;
        w_drop_n   = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_gnt_vec[i]  = w_grant_en && (w_gnt_idx == c_SLOT_W'(i));
            w_drop_vec[i] = !clear && in_valid[i] && r_pending[i] && !w_gnt_vec[i];
            w_drop_n      = w_drop_n + {{c_SLOT_W{1'b0}}, w_drop_vec[i]};
        end
        w_drop_sum  = c_DW'(r_drop) + c_DW'(w_drop_n);
        w_drop_next = (|w_drop_sum[c_DW-1:CNT_W]) ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];
    end

    // Slot capture: a granted slot hands its old source to the FIFO and may
    // re-capture a new event in the same cycle without losing it.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_pending <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) r_src[i] <= '0;
        end else if (clear) begin
            r_pending <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (in_valid[i] && (!r_pending[i] || w_gnt_vec[i])) begin
                    r_pending[i] <= 1'b1;
                    r_src[i]     <= in_source[i*ADDR_W +: ADDR_W];
                end else if (w_gnt_vec[i]) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointer and dropped-event counter.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_ptr  <= '0;
            r_drop <= '0;
        end else begin
            if (w_grant_en) r_ptr <= wrap_add(w_gnt_idx, 1);
            r_drop <= w_drop_next;
        end
    end

    // Packet FIFO; storage is cleared on reset so the head reads zero.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                r_mem_dest[j] <= '0;
                r_mem_src[j]  <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem_dest[r_wr] <= ADDR_W'(w_gnt_idx);
                r_mem_src[r_wr]  <= r_src[w_gnt_idx];
                r_wr             <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_valid  = (r_count != '0);
    assign out_dest   = r_mem_dest[r_rd];
    assign out_source = r_mem_src[r_rd];
    assign fifo_count = r_count;
    assign drop_count = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_spike_packet_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_spike_packet_queue
// Description : Self-checking bench for spike_packet_queue: a table of
//               per-cycle vectors plus directed multi-cycle sequences for
//               back-pressure, collisions, clear, saturation and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_packet_queue;

    localparam int c_NS = 10;
    localparam int c_AW = 12;

    logic               CLK = 1'b0;
    logic               reset;
    logic               clear;
    logic [c_NS-1:0]    in_valid;
    logic [c_NS*c_AW-1:0] in_source;
    logic               out_valid;
    logic               out_ready;
    logic [c_AW-1:0]    out_dest;
    logic [c_AW-1:0]    out_source;
    logic [3:0]         fifo_count;
    logic [15:0]        drop_count;

    int n_chk = 0;
    int n_err = 0;

    spike_packet_queue #(
        .NUM_SLOTS(c_NS), .ADDR_W(c_AW), .FIFO_DEPTH(8), .CNT_W(16)
    ) dut (
        .CLK(CLK), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_source(in_source),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_dest(out_dest), .out_source(out_source),
        .fifo_count(fifo_count), .drop_count(drop_count)
    );

    // 10 ns clock
    always #5 CLK = ~CLK;

    // Watchdog so the run can never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic        clr;
        logic [9:0]  vld;
        logic [11:0] src;
        logic        inc;      // slot i gets src+i when set
        logic        rdy;
        logic        e_ov;
        logic        chk_data; // compare head dest/source
        logic [11:0] e_dest;
        logic [11:0] e_src;
        logic [3:0]  e_cnt;
        logic [15:0] e_drop;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic clr, input logic [9:0] vld,
                                input logic [11:0] src, input logic inc, input logic rdy,
                                input logic e_ov, input logic chk_data,
                                input logic [11:0] e_dest, input logic [11:0] e_src,
                                input logic [3:0] e_cnt, input logic [15:0] e_drop);
        vec_t v;
        v.rst = rst; v.clr = clr; v.vld = vld; v.src = src; v.inc = inc; v.rdy = rdy;
        v.e_ov = e_ov; v.chk_data = chk_data; v.e_dest = e_dest; v.e_src = e_src;
        v.e_cnt = e_cnt; v.e_drop = e_drop;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive inputs just after an edge, advance one edge, settle 1 ns.
    task automatic step(input logic rst, input logic clr, input logic [9:0] vld,
                        input logic [11:0] src, input logic inc, input logic rdy);
        reset     = rst;
        clear     = clr;
        in_valid  = vld;
        out_ready = rdy;
        for (int i = 0; i < c_NS; i++)
            in_source[i*c_AW +: c_AW] = src + (inc ? 12'(i) : 12'd0);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 10'h000, 12'h000, 1'b0, rdy);
    endtask

    task automatic chk_head(input string name, input int dest, input int src);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_dest"},  32'(out_dest),  32'(dest));
        chk({name, "_src"},   32'(out_source), 32'(src));
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = '0; in_source = '0; out_ready = 1'b0;

        // ---------------- vector table ----------------
        // reset state
        add(1,0,10'h000,12'h000,0,0, 0,1,12'd0,12'h000,4'd0,16'd0);
        // single event on slot 3: out_valid two edges after capture
        add(0,0,10'h008,12'h005,0,0, 0,0,12'd0,12'h000,4'd0,16'd0);
        add(0,0,10'h000,12'h000,0,0, 1,1,12'd3,12'h005,4'd1,16'd0);
        add(0,0,10'h000,12'h000,0,1, 0,0,12'd0,12'h000,4'd0,16'd0);
        // fan-out burst: slot 8 re-captured in its grant cycle (ptr=4 here)
        add(0,0,10'h300,12'h003,0,1, 0,0,12'd0,12'h000,4'd0,16'd0);
        add(0,0,10'h100,12'h005,0,1, 1,1,12'd8,12'h003,4'd1,16'd0);
        add(0,0,10'h000,12'h000,0,1, 1,1,12'd9,12'h003,4'd1,16'd0);
        add(0,0,10'h000,12'h000,0,1, 1,1,12'd8,12'h005,4'd1,16'd0);
        add(0,0,10'h000,12'h000,0,1, 0,0,12'd0,12'h000,4'd0,16'd0);
        // round-robin from ptr=0
        add(1,0,10'h000,12'h000,0,1, 0,1,12'd0,12'h000,4'd0,16'd0);
        add(0,0,10'h3FF,12'h100,1,1, 0,0,12'd0,12'h000,4'd0,16'd0);
        for (int k = 0; k < 10; k++)
            add(0,0,10'h000,12'h000,0,1, 1,1,12'(k),12'(12'h100 + k),4'd1,16'd0);
        add(0,0,10'h000,12'h000,0,1, 0,0,12'd0,12'h000,4'd0,16'd0);
        // move ptr to 4 with a slot-3 event, then a second full burst
        add(0,0,10'h008,12'h033,0,1, 0,0,12'd0,12'h000,4'd0,16'd0);
        add(0,0,10'h000,12'h000,0,1, 1,1,12'd3,12'h033,4'd1,16'd0);
        add(0,0,10'h3FF,12'h200,1,1, 0,0,12'd0,12'h000,4'd0,16'd0);
        for (int k = 0; k < 10; k++)
            add(0,0,10'h000,12'h000,0,1, 1,1,12'((4+k)%10),12'(12'h200 + (4+k)%10),4'd1,16'd0);
        add(0,0,10'h000,12'h000,0,1, 0,0,12'd0,12'h000,4'd0,16'd0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].clr, vecs[i].vld, vecs[i].src, vecs[i].inc, vecs[i].rdy);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid),  32'(vecs[i].e_ov));
            chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_drop", i),  32'(drop_count), 32'(vecs[i].e_drop));
            if (vecs[i].chk_data) begin
                chk($sformatf("vec%0d_dest", i), 32'(out_dest),   32'(vecs[i].e_dest));
                chk($sformatf("vec%0d_src", i),  32'(out_source), 32'(vecs[i].e_src));
            end
        end

        // ---------------- back-pressure and full ----------------
        step(1,0,10'h000,12'h000,0,0);
        step(0,0,10'h3FF,12'h300,1,0);
        repeat (8) idle(1'b0);
        chk("bp_count_full", 32'(fifo_count), 32'd8);
        chk_head("bp_head0", 0, 12'h300);
        idle(1'b0);
        chk("bp_hold_full", 32'(fifo_count), 32'd8);
        chk_head("bp_head0_held", 0, 12'h300);
        idle(1'b1);
        chk("bp_pop_no_push", 32'(fifo_count), 32'd7);
        idle(1'b0);
        chk("bp_push_ninth", 32'(fifo_count), 32'd8);
        for (int k = 1; k <= 9; k++) begin
            chk_head($sformatf("bp_drain%0d", k), k, 12'h300 + k);
            idle(1'b1);
        end
        chk("bp_empty", 32'(fifo_count), 32'd0);

        // ---------------- collision drop ----------------
        step(1,0,10'h000,12'h000,0,0);
        step(0,0,10'h0FF,12'h010,1,0);
        repeat (8) idle(1'b0);
        chk("col_full", 32'(fifo_count), 32'd8);
        step(0,0,10'h020,12'h055,0,0);
        chk("col_no_drop_yet", 32'(drop_count), 32'd0);
        repeat (3) step(0,0,10'h020,12'h0EE,0,0);
        chk("col_drop3", 32'(drop_count), 32'd3);
        for (int k = 0; k < 9; k++) begin
            if (k < 8) chk_head($sformatf("col_drain%0d", k), k, 12'h010 + k);
            else       chk_head("col_orig_src", 5, 12'h055);
            idle(1'b1);
        end
        chk("col_empty", 32'(fifo_count), 32'd0);
        chk("col_drop_kept", 32'(drop_count), 32'd3);

        // ---------------- clear ----------------
        step(1,0,10'h000,12'h000,0,0);
        step(0,0,10'h011,12'h0C0,0,0);
        idle(1'b0);
        idle(1'b0);
        chk("clr_two_entries", 32'(fifo_count), 32'd2);
        step(0,0,10'h006,12'h0D0,0,0);
        step(0,1,10'h008,12'h0F0,0,0);
        chk("clr_no_push", 32'(fifo_count), 32'd2);
        chk("clr_no_drop", 32'(drop_count), 32'd0);
        chk_head("clr_head0", 0, 12'h0C0);
        idle(1'b1);
        chk_head("clr_head4", 4, 12'h0C0);
        idle(1'b1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("clr_nothing%0d", k), 32'(out_valid), 32'd0);
            idle(1'b1);
        end
        chk("clr_count0", 32'(fifo_count), 32'd0);

        // ---------------- drop saturation, then reset ----------------
        step(1,0,10'h000,12'h000,0,0);
        step(0,0,10'h3FF,12'h400,1,0);
        repeat (8) idle(1'b0);
        step(0,0,10'h0FF,12'h500,0,0);
        chk("sat_start", 32'(drop_count), 32'd0);
        repeat (6553) step(0,0,10'h3FF,12'h600,0,0);
        chk("sat_65530", 32'(drop_count), 32'd65530);
        step(0,0,10'h3FF,12'h600,0,0);
        chk("sat_ffff", 32'(drop_count), 32'hFFFF);
        step(0,0,10'h020,12'h600,0,0);
        chk("sat_hold", 32'(drop_count), 32'hFFFF);
        chk("sat_full", 32'(fifo_count), 32'd8);
        step(1,1,10'h3FF,12'h700,0,1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_dest", 32'(out_dest), 32'd0);
        chk("rst_src", 32'(out_source), 32'd0);
        idle(1'b1);
        idle(1'b1);
        chk("rst_pending_lost", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
